// File: rtl/aes_fsm_decrypt.sv
// Toy 8-bit AES round decryptor: expands the key forward to k(R),
// then unwinds one round per clock back to the plaintext byte.
module aes_fsm_decrypt #(
    parameter int NUM_ROUNDS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cipher_in,
    input  logic [7:0] key_in,
    output logic [7:0] plain_out,
    output logic       ready,
    output logic       busy,
    output logic [2:0] state_o,
    output logic [2:0] round_o
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] KEY_EXPAND = 3'd1;
    localparam logic [2:0] WHITEN     = 3'd2;
    localparam logic [2:0] ROUND      = 3'd3;
    localparam logic [2:0] DONE       = 3'd4;

    localparam logic [2:0] LAST = 3'(NUM_ROUNDS);

    function automatic logic [3:0] sinv4(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            4'hF: y = 4'hA;
        endcase
        return y;
    endfunction

    logic [2:0] state;
    logic [2:0] cnt;
    logic [7:0] data;
    logic [7:0] key;
    logic [7:0] kp;
    logic [7:0] key_fwd;
    logic [7:0] data_inv;

    // Inverse round: undo swap, then Sinv per nibble, then add k(r-1)
    assign kp       = {key[0] ^ cnt[0], key[7:1] ^ {4'd0, cnt[2:1]}};
    assign data_inv = {sinv4(data[3:0]), sinv4(data[7:4])} ^ kp;
    assign key_fwd  = {key[6:0], key[7]} ^ {5'd0, cnt + 3'd1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            data      <= 8'h00;
            key       <= 8'h00;
            plain_out <= 8'h00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        data  <= cipher_in;
                        key   <= key_in;
                        cnt   <= 3'd0;
                        state <= KEY_EXPAND;
                    end
                end
                KEY_EXPAND: begin
                    key <= key_fwd;
                    cnt <= cnt + 3'd1;
                    if (cnt == LAST - 3'd1)
                        state <= WHITEN;
                end
                WHITEN: begin
                    data  <= data ^ key;
                    state <= ROUND;
                end
                ROUND: begin
                    data <= data_inv;
                    key  <= kp;
                    cnt  <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        plain_out <= data_inv;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready   = (state == DONE);
    assign busy    = (state == KEY_EXPAND) || (state == WHITEN)
                  || (state == ROUND);
    assign state_o = state;
    assign round_o = cnt;

endmodule

// File: tb/tb_aes_fsm_decrypt.sv
// Directed bench for aes_fsm_decrypt: scoreboard of expected plaintexts,
// reference encryptor for round-trip vectors.
module tb_aes_fsm_decrypt;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cipher_in;
    logic [7:0] key_in;
    logic [7:0] plain_out;
    logic       ready;
    logic       busy;
    logic [2:0] state_o;
    logic [2:0] round_o;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb_q[$];

    aes_fsm_decrypt #(.NUM_ROUNDS(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cipher_in (cipher_in),
        .key_in    (key_in),
        .plain_out (plain_out),
        .ready     (ready),
        .busy      (busy),
        .state_o   (state_o),
        .round_o   (round_o)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] t[16];
        t = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        return t[x];
    endfunction

    function automatic logic [7:0] encrypt(input logic [7:0] p,
                                           input logic [7:0] k);
        logic [7:0] s;
        logic [7:0] kk;
        s  = p ^ k;
        kk = k;
        for (int r = 1; r <= R; r++) begin
            kk = {kk[6:0], kk[7]} ^ 8'(r);
            s  = {sbox4(s[3:0]), sbox4(s[7:4])} ^ kk;
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [7:0] c, input logic [7:0] k,
                       input logic [7:0] exp, input bit noise,
                       input bit mon);
        int n;
        bit bad_busy;
        logic [7:0] want;
        logic [2:0] est[10];
        logic [2:0] ecnt[10];
        est  = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2,
                 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        ecnt = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        sb_q.push_back(exp);
        cipher_in = c;
        key_in    = k;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("accept_ready", 8'(ready), 8'd0);
        check("accept_state", 8'(state_o), 8'd1);
        if (mon) check("mon_cnt0", 8'(round_o), 8'(ecnt[0]));
        bad_busy = 1'b0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (mon && n <= 9) begin
                check($sformatf("mon_state%0d", n), 8'(state_o), 8'(est[n]));
                check($sformatf("mon_cnt%0d", n), 8'(round_o), 8'(ecnt[n]));
            end
            if (ready) break;
            if (!busy) bad_busy = 1'b1;
            if (noise) begin
                start     = 1'b1;
                cipher_in = 8'($urandom);
                key_in    = 8'($urandom);
            end
        end
        start = 1'b0;
        check("latency", 8'(n), 8'(2 * R + 1));
        check("busy_window", 8'(bad_busy), 8'd0);
        want = sb_q.pop_front();
        check("plain", plain_out, want);
    endtask

    initial begin
        logic [7:0] p;
        logic [7:0] k;
        logic [7:0] held;
        bit unstable;
        logic [7:0] pairs[8];

        rst       = 1'b1;
        start     = 1'b0;
        cipher_in = 8'h00;
        key_in    = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check("rst_plain", plain_out, 8'h00);
        check("rst_ready", 8'(ready), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_state", 8'(state_o), 8'd0);
        check("rst_round", 8'(round_o), 8'd0);

        run(8'h1C, 8'h00, 8'h00, 1'b0, 1'b0);
        run(8'h0B, 8'h55, 8'hAA, 1'b0, 1'b1);

        pairs = '{8'h12, 8'h34, 8'hFF, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            p = pairs[2*i];
            k = pairs[2*i+1];
            run(encrypt(p, k), k, p, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            p = 8'($urandom);
            k = 8'($urandom);
            run(encrypt(p, k), k, p, 1'b0, 1'b0);
        end

        run(8'h0B, 8'h55, 8'hAA, 1'b1, 1'b0);

        cipher_in = 8'h0B;
        key_in    = 8'h55;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("pre_rst_state", 8'(state_o), 8'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_state", 8'(state_o), 8'd0);
        check("mid_rst_ready", 8'(ready), 8'd0);
        check("mid_rst_plain", plain_out, 8'h00);
        check("mid_rst_round", 8'(round_o), 8'd0);
        run(8'h0B, 8'h55, 8'hAA, 1'b0, 1'b0);

        held = plain_out;
        unstable = 1'b0;
        repeat (20) begin
            tick();
            if (ready !== 1'b1 || plain_out !== held) unstable = 1'b1;
        end
        check("done_hold", 8'(unstable), 8'd0);
        check("done_hold_plain", plain_out, 8'hAA);
        run(8'h1C, 8'h00, 8'h00, 1'b0, 1'b0);

        check("sb_empty", 8'(sb_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
